// File: rtl/oam_dma_arbiter_if.sv
// Bus-op encoding plus the CPU-side and MMU-side request/response bundle around the OAM DMA arbiter.
// The package is declared here so that it is compiled before both the interface and the arbiter.
package oam_dma_pkg;
   typedef enum logic [1:0] {
      BUS_IDLE  = 2'd0,
      BUS_READ  = 2'd1,
      BUS_WRITE = 2'd2
   } bus_op_t;
endpackage

interface oam_dma_arbiter_if;
   import oam_dma_pkg::*;

   bus_op_t     cpu_bus_op;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   bus_op_t     mmu_bus_op;
   logic [15:0] mmu_addr;
   logic [7:0]  mmu_wdata;
   logic [7:0]  mmu_rdata;
   logic        dma_active;

   // master drives CPU requests and returns MMU read data; slave is the arbiter
   modport master (
      output cpu_bus_op, cpu_addr, cpu_wdata, mmu_rdata,
      input  cpu_rdata, mmu_bus_op, mmu_addr, mmu_wdata, dma_active
   );
   modport slave (
      input  cpu_bus_op, cpu_addr, cpu_wdata, mmu_rdata,
      output cpu_rdata, mmu_bus_op, mmu_addr, mmu_wdata, dma_active
   );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Owns the MMU request port: passes CPU traffic through when idle and runs the OAM DMA copy,
// blocking CPU traffic while a transfer is in progress.
module oam_dma_arbiter
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] OAM_BASE     = 16'hFE00,
   parameter int          XFER_LEN     = 160,
   parameter int          START_DELAY  = 1
) (
   input logic               clk,
   input logic               reset,
   oam_dma_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} state_t;

   state_t     state_reg, state_next;
   logic [7:0] idx_reg, idx_next;
   logic [7:0] src_hi_reg, src_hi_next;
   logic [7:0] cnt_reg, cnt_next;
   logic       blk_rd_reg, blk_rd_next;
   logic       reg_rd_reg, reg_rd_next;

   logic       trigger;
   logic       reg_read;
   logic [7:0] eff_hi;

   assign trigger  = (bus.cpu_bus_op == BUS_WRITE) && (bus.cpu_addr == DMA_REG_ADDR);
   assign reg_read = (bus.cpu_bus_op == BUS_READ)  && (bus.cpu_addr == DMA_REG_ADDR);
   // Sources in echo RAM (E0..FF) fold back onto work RAM (C0..DF)
   assign eff_hi   = (src_hi_reg >= 8'hE0) ? (src_hi_reg - 8'h20) : src_hi_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         idx_reg    <= '0;
         src_hi_reg <= '0;
         cnt_reg    <= '0;
         blk_rd_reg <= 1'b0;
         reg_rd_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         src_hi_reg <= src_hi_next;
         cnt_reg    <= cnt_next;
         blk_rd_reg <= blk_rd_next;
         reg_rd_reg <= reg_rd_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      src_hi_next    = src_hi_reg;
      cnt_next       = cnt_reg;
      blk_rd_next    = 1'b0;
      reg_rd_next    = reg_read;
      bus.mmu_bus_op = BUS_IDLE;
      bus.mmu_addr   = '0;
      bus.mmu_wdata  = '0;

      case (state_reg)
         S_IDLE: begin
            if (!reg_read) begin
               bus.mmu_bus_op = bus.cpu_bus_op;
               bus.mmu_addr   = bus.cpu_addr;
               bus.mmu_wdata  = bus.cpu_wdata;
            end
         end
         S_START: begin
            if (cnt_reg == 8'd0) state_next = S_READ;
            else                 cnt_next   = cnt_reg - 8'd1;
         end
         S_READ: begin
            bus.mmu_bus_op = BUS_READ;
            bus.mmu_addr   = {eff_hi, idx_reg};
            state_next     = S_WRITE;
         end
         S_WRITE: begin
            bus.mmu_bus_op = BUS_WRITE;
            bus.mmu_addr   = OAM_BASE + {8'h00, idx_reg};
            bus.mmu_wdata  = bus.mmu_rdata;
            idx_next       = idx_reg + 8'd1;
            state_next     = (idx_reg == 8'(XFER_LEN - 1)) ? S_IDLE : S_READ;
         end
         default: state_next = S_IDLE;
      endcase

      if (state_reg != S_IDLE) blk_rd_next = (bus.cpu_bus_op == BUS_READ);

      // A trigger always wins, including over the final WRITE's return to IDLE
      if (trigger) begin
         src_hi_next = bus.cpu_wdata;
         idx_next    = '0;
         cnt_next    = 8'(START_DELAY - 1);
         state_next  = S_START;
      end

      if (reset) bus.mmu_bus_op = BUS_IDLE;
   end

   assign bus.dma_active = (state_reg != S_IDLE);
   assign bus.cpu_rdata  = reg_rd_reg ? src_hi_reg :
                           blk_rd_reg ? 8'hFF      : bus.mmu_rdata;

endmodule
